// File: rtl/ntt_bfu_pkg.sv
// Shared constants for the NTT butterfly datapath (Kyber, q = 3329).
// DW_DEF : coefficient / twiddle width
// Q_DEF  : modulus
// BK_DEF : Barrett shift k, (Q-1)^2 < 2^BK
// BM_DEF : Barrett constant floor(2^BK / Q)
package ntt_bfu_pkg;

  localparam int DW_DEF = 12;
  localparam int Q_DEF  = 3329;
  localparam int BK_DEF = 24;
  localparam int BM_DEF = 5039;

endpackage

// File: rtl/ntt_bfu_mod_mul_barrett.sv
// Pipelined Barrett modular multiplier: z = (x * y) mod Q, latency 4.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   x, y, vin   : operands (< Q) and their valid flag
//   z, vout     : reduced product and its valid flag, 4 cycles later
module mod_mul_barrett
  import ntt_bfu_pkg::*;
#(
  parameter int DATA_W = DW_DEF,
  parameter int Q      = Q_DEF,
  parameter int BK     = BK_DEF,
  parameter int BM     = BM_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              vin,
  output logic [DATA_W-1:0] z,
  output logic              vout
);

  localparam int PW = 2 * DATA_W;        // full product width
  localparam int MW = PW + DATA_W + 1;   // product times Barrett constant
  localparam int RW = DATA_W + 1;        // residue in [0, 2Q)
  localparam int QW = MW - BK;           // quotient estimate width

  // Single conditional subtraction: maps [0, 2Q) onto [0, Q).
  function automatic logic [RW-1:0] csub(input logic [RW-1:0] v);
    return (v >= RW'(Q)) ? v - RW'(Q) : v;
  endfunction

  logic [PW-1:0] prod_p1, prod_p2;
  logic [QW-1:0] quot_p2;
  logic [RW-1:0] res_p3;
  logic          vld_p1, vld_p2, vld_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      prod_p2 <= '0;
      quot_p2 <= '0;
      vld_p2  <= 1'b0;
      res_p3  <= '0;
      vld_p3  <= 1'b0;
      z       <= '0;
      vout    <= 1'b0;
    end else begin
      // S1: raw product
      prod_p1 <= PW'(x) * PW'(y);
      vld_p1  <= vin;
      // S2: quotient estimate, never above the true quotient
      quot_p2 <= QW'((MW'(prod_p1) * MW'(BM)) >> BK);
      prod_p2 <= prod_p1;
      vld_p2  <= vld_p1;
      // S3: residue, the estimate is short by at most one Q
      res_p3  <= RW'(prod_p2 - PW'(quot_p2) * PW'(Q));
      vld_p3  <= vld_p2;
      // S4: final reduction
      z       <= DATA_W'(csub(res_p3));
      vout    <= vld_p3;
    end
  end

endmodule

// File: rtl/ntt_bfu.sv
// Cooley-Tukey butterfly for the NTT datapath, modulus Q = 3329.
// out_a = (a + w*b) mod Q, out_b = (a - w*b) mod Q, fixed latency 5,
// one butterfly per cycle, no stalls.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid              : operands valid (from address generator enable)
//   in_a, in_b, in_w      : coefficients and twiddle, all < Q
//   out_valid             : results valid (to address generator valid)
//   out_a, out_b          : butterfly results
module ntt_bfu
  import ntt_bfu_pkg::*;
#(
  parameter int DATA_W = DW_DEF,
  parameter int Q      = Q_DEF,
  parameter int BK     = BK_DEF,
  parameter int BM     = BM_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_w,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  localparam int RW = DATA_W + 1;

  function automatic logic [RW-1:0] csub(input logic [RW-1:0] v);
    return (v >= RW'(Q)) ? v - RW'(Q) : v;
  endfunction

  logic [DATA_W-1:0] m_p4;
  logic              vld_p4;
  logic [DATA_W-1:0] a_p1, a_p2, a_p3, a_p4;
  logic [RW-1:0]     sum_p4, dif_p4;

  mod_mul_barrett #(
    .DATA_W (DATA_W),
    .Q      (Q),
    .BK     (BK),
    .BM     (BM)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (in_w),
    .y     (in_b),
    .vin   (in_valid),
    .z     (m_p4),
    .vout  (vld_p4)
  );

  // S1..S4: a travels alongside the multiplier pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1 <= '0;
      a_p2 <= '0;
      a_p3 <= '0;
      a_p4 <= '0;
    end else begin
      a_p1 <= in_a;
      a_p2 <= a_p1;
      a_p3 <= a_p2;
      a_p4 <= a_p3;
    end
  end

  // S5: add/sub; Q is added before subtracting so the difference stays positive
  always_comb begin
    sum_p4 = RW'(a_p4) + RW'(m_p4);
    dif_p4 = RW'(a_p4) + RW'(Q) - RW'(m_p4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_a     <= DATA_W'(csub(sum_p4));
      out_b     <= DATA_W'(csub(dif_p4));
      out_valid <= vld_p4;
    end
  end

endmodule
